// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and CDC pointer logic.
// Functions work on a fixed maximum width; callers zero-extend and truncate.
package gray_pkg;

   localparam int unsigned GRAY_MAX_W = 32;

   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   // Largest count representable in 'width' bits.
   function automatic gray_word_t max_count(input int unsigned width);
      if (width >= GRAY_MAX_W)
         return '1;
      return gray_word_t'((64'd1 << width) - 64'd1);
   endfunction

   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Binary bit i is the XOR of all Gray bits at or above i.
   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b = '0;
      for (int unsigned i = 0; i < GRAY_MAX_W; i++)
         b[i] = ^(g >> i);
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational WIDTH-bit Gray-to-binary decoder (prefix XOR from the MSB down).
module gray2bin_conv #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   always_comb begin
      bin = '0;
      for (int unsigned i = 0; i < WIDTH; i++)
         bin[i] = ^(gray >> i);
   end

endmodule

// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray counter with enable, parallel load, wrap/saturate
// mode, registered binary mirror and a one-cycle boundary flag.
module gray_updown_counter
   import gray_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH));

   logic [WIDTH-1:0] load_bin;
   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] bin_d;
   logic             wrap_d;

   gray2bin_conv #(.WIDTH(WIDTH)) u_load_dec (
      .gray (load_gray),
      .bin  (load_bin)
   );

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (load) begin
         bin_d = load_bin;
      end else if (en) begin
         if (up) begin
            if (bin_q == MAX) begin
               wrap_d = 1'b1;
               bin_d  = SATURATE ? bin_q : '0;
            end else begin
               bin_d = bin_q + 1'b1;
            end
         end else begin
            if (bin_q == '0) begin
               wrap_d = 1'b1;
               bin_d  = SATURATE ? bin_q : MAX;
            end else begin
               bin_d = bin_q - 1'b1;
            end
         end
      end
   end

   // Gray is encoded from the next binary value so both outputs change on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q    <= '0;
         gray_out <= '0;
         wrap     <= 1'b0;
      end else begin
         bin_q    <= bin_d;
         gray_out <= WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
         wrap     <= wrap_d;
      end
   end

   assign bin_out = bin_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: directed cases at WIDTH=4 (wrap and saturate)
// plus a randomized WIDTH=8 run against an integer reference model.
module tb_gray_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, en_a, up_a, load_a, wrap_a;
   logic [3:0] lg_a, gray_a, bin_a;
   logic       rst_s, en_s, up_s, load_s, wrap_s;
   logic [3:0] lg_s, gray_s, bin_s;
   logic       rst_b, en_b, up_b, load_b, wrap_b;
   logic [7:0] lg_b, gray_b, bin_b;

   gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .load(load_a), .load_gray(lg_a),
      .gray_out(gray_a), .bin_out(bin_a), .wrap(wrap_a));

   gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst(rst_s), .en(en_s), .up(up_s), .load(load_s), .load_gray(lg_s),
      .gray_out(gray_s), .bin_out(bin_s), .wrap(wrap_s));

   gray_updown_counter #(.WIDTH(8), .SATURATE(1'b0)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .load(load_b), .load_gray(lg_b),
      .gray_out(gray_b), .bin_out(bin_b), .wrap(wrap_b));

   int checks = 0;
   int errors = 0;

   int mb_a = 0, mb_s = 0, mb_b = 0;
   bit mw_a = 1'b0, mw_s = 1'b0, mw_b = 1'b0;

   logic [3:0] seq2 [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                             4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Finds the count whose Gray code equals g by searching the whole code space.
   function automatic int decode(input int w, input int g);
      int r = 0;
      for (int v = 0; v < (1 << w); v++)
         if ((v ^ (v >> 1)) == g) r = v;
      return r;
   endfunction

   task automatic model(input int w, input bit sat, input logic r, input logic ld,
                        input logic e, input logic u, input int lg,
                        inout int b, inout bit wr);
      int mx = (1 << w) - 1;
      if (r) begin
         b = 0; wr = 1'b0;
      end else if (ld) begin
         b = decode(w, lg); wr = 1'b0;
      end else if (e && u) begin
         if (b == mx) begin wr = 1'b1; if (!sat) b = 0; end
         else begin b = b + 1; wr = 1'b0; end
      end else if (e) begin
         if (b == 0) begin wr = 1'b1; if (!sat) b = mx; end
         else begin b = b - 1; wr = 1'b0; end
      end else begin
         wr = 1'b0;
      end
   endtask

   task automatic check_dut(input string name, input int w, input int mb, input bit mw,
                            input logic [31:0] g, input logic [31:0] bn, input logic wr);
      check({name, ".gray"}, g, 32'(mb ^ (mb >> 1)));
      check({name, ".bin"}, bn, 32'(mb));
      check({name, ".wrap"}, {31'd0, wr}, {31'd0, mw});
      check({name, ".bin_vs_gray"}, bn, 32'(decode(w, int'(g))));
   endtask

   task automatic do_edge();
      logic [3:0] pg_a, pg_s;
      logic [7:0] pg_b;
      int pb_a, pb_s, pb_b;
      bit st_a, st_s, st_b;
      pg_a = gray_a; pg_s = gray_s; pg_b = gray_b;
      pb_a = mb_a;   pb_s = mb_s;   pb_b = mb_b;
      st_a = !rst_a && !load_a && en_a;
      st_s = !rst_s && !load_s && en_s;
      st_b = !rst_b && !load_b && en_b;
      model(4, 1'b0, rst_a, load_a, en_a, up_a, int'(lg_a), mb_a, mw_a);
      model(4, 1'b1, rst_s, load_s, en_s, up_s, int'(lg_s), mb_s, mw_s);
      model(8, 1'b0, rst_b, load_b, en_b, up_b, int'(lg_b), mb_b, mw_b);
      @(posedge clk);
      #1;
      check_dut("a", 4, mb_a, mw_a, 32'(gray_a), 32'(bin_a), wrap_a);
      check_dut("s", 4, mb_s, mw_s, 32'(gray_s), 32'(bin_s), wrap_s);
      check_dut("b", 8, mb_b, mw_b, 32'(gray_b), 32'(bin_b), wrap_b);
      if (st_a && mb_a != pb_a) check("a.hamming", 32'($countones(gray_a ^ pg_a)), 32'd1);
      if (st_s && mb_s != pb_s) check("s.hamming", 32'($countones(gray_s ^ pg_s)), 32'd1);
      if (st_b && mb_b != pb_b) check("b.hamming", 32'($countones(gray_b ^ pg_b)), 32'd1);
   endtask

   initial begin
      int bias;
      {rst_a, en_a, up_a, load_a, lg_a} = '0;
      {rst_s, en_s, up_s, load_s, lg_s} = '0;
      {rst_b, en_b, up_b, load_b, lg_b} = '0;
      rst_a = 1'b1; rst_s = 1'b1; rst_b = 1'b1;
      en_a = 1'b1; up_a = 1'b1; en_s = 1'b1; up_s = 1'b1; en_b = 1'b1; up_b = 1'b1;
      #2;

      // reset holds everything at zero even while enabled
      for (int i = 0; i < 2; i++) begin
         do_edge();
         check("t1.gray", 32'(gray_a), 32'h0);
         check("t1.bin", 32'(bin_a), 32'h0);
         check("t1.wrap", {31'd0, wrap_a}, 32'h0);
      end
      rst_a = 1'b0; rst_s = 1'b0; rst_b = 1'b0;
      en_s = 1'b0; en_b = 1'b0;

      // full up cycle
      for (int i = 0; i < 16; i++) begin
         do_edge();
         check("t2.seq", 32'(gray_a), 32'(seq2[i]));
         check("t2.wrap", {31'd0, wrap_a}, (i == 15) ? 32'h1 : 32'h0);
      end

      // down from zero wraps to MAX
      up_a = 1'b0;
      do_edge();
      check("t3.gray", 32'(gray_a), 32'h8);
      check("t3.bin", 32'(bin_a), 32'hf);
      check("t3.wrap", {31'd0, wrap_a}, 32'h1);
      do_edge();
      check("t3.gray2", 32'(gray_a), 32'h9);
      check("t3.wrap2", {31'd0, wrap_a}, 32'h0);

      // load beats count
      load_a = 1'b1; lg_a = 4'b1101; up_a = 1'b1;
      do_edge();
      check("t4.gray", 32'(gray_a), 32'hd);
      check("t4.bin", 32'(bin_a), 32'h9);
      load_a = 1'b0;
      do_edge();
      check("t4.next", 32'(gray_a), 32'hf);

      // hold with en low
      en_a = 1'b0;
      do_edge();
      check("hold.gray", 32'(gray_a), 32'hf);
      check("hold.wrap", {31'd0, wrap_a}, 32'h0);

      // saturate at MAX, then step back down
      load_s = 1'b1; lg_s = 4'b1000;
      do_edge();
      load_s = 1'b0; en_s = 1'b1; up_s = 1'b1;
      for (int i = 0; i < 3; i++) begin
         do_edge();
         check("t5.gray", 32'(gray_s), 32'h8);
         check("t5.wrap", {31'd0, wrap_s}, 32'h1);
      end
      up_s = 1'b0;
      do_edge();
      check("t5.down", 32'(gray_s), 32'h9);
      check("t5.wrap2", {31'd0, wrap_s}, 32'h0);
      en_s = 1'b0;

      // reset mid-count overrides load and en
      rst_a = 1'b1;
      do_edge();
      rst_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
      for (int i = 0; i < 4; i++) do_edge();
      check("t6.pre", 32'(gray_a), 32'h6);
      rst_a = 1'b1; load_a = 1'b1; lg_a = 4'b1011;
      do_edge();
      check("t6.gray", 32'(gray_a), 32'h0);
      check("t6.bin", 32'(bin_a), 32'h0);
      check("t6.wrap", {31'd0, wrap_a}, 32'h0);
      rst_a = 1'b0; load_a = 1'b0;

      // randomized run on all instances, direction biased in long phases so boundaries are crossed
      bias = 90;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) bias = 100 - bias;
         rst_a  = ($urandom_range(0, 63) == 0);
         load_a = ($urandom_range(0, 7) == 0);
         en_a   = ($urandom_range(0, 3) != 0);
         up_a   = ($urandom_range(0, 99) < bias);
         lg_a   = 4'($urandom);
         rst_s  = ($urandom_range(0, 63) == 0);
         load_s = ($urandom_range(0, 7) == 0);
         en_s   = ($urandom_range(0, 3) != 0);
         up_s   = ($urandom_range(0, 99) < bias);
         lg_s   = 4'($urandom);
         rst_b  = ($urandom_range(0, 127) == 0);
         load_b = ($urandom_range(0, 15) == 0);
         en_b   = ($urandom_range(0, 3) != 0);
         up_b   = ($urandom_range(0, 99) < bias);
         lg_b   = 8'($urandom);
         do_edge();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
